// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one cache CPU-side port among NUM_REQ requesters.
// Optional watchdog abort of stuck accesses when ARB_TIMEOUT_EN is defined.
module cache_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          reqValid_Req,
  input  logic [NUM_REQ*ADDR_W-1:0]   reqAddress_Req,
  input  logic [NUM_REQ*DATA_W-1:0]   reqDataIn_Req,
  input  logic [NUM_REQ-1:0]          reqWen_Req,
  output logic [DATA_W-1:0]           respDataOut_Req,
  output logic [NUM_REQ-1:0]          respHit_Req,
  output logic [NUM_REQ-1:0]          respErr_Req,
  output logic                        reqValid_CPU,
  output logic [ADDR_W-1:0]           reqAddress_CPU,
  output logic [DATA_W-1:0]           reqDataIn_CPU,
  output logic                        reqWen_CPU,
  input  logic [DATA_W-1:0]           respDataOut_CPU,
  input  logic                        respHit_CPU,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);
  localparam int IDX_W = $clog2(NUM_REQ);
  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t              state_q, state_d;
  idx_t                last_q, last_d;
  idx_t                grant_q, grant_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]  hit_q, hit_d;

  idx_t                pick_idx;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_data;
  logic                pick_wen;
  logic                pick_any;
  int                  pick_dist;
  int                  cand_dist;

`ifdef ARB_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Requester distance from the one after last_q; the smallest valid distance wins.
  always_comb begin
    pick_idx  = '0;
    pick_addr = '0;
    pick_data = '0;
    pick_wen  = 1'b0;
    pick_dist = NUM_REQ;
    cand_dist = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand_dist = (j - int'(last_q) - 1 + NUM_REQ) % NUM_REQ;
      if (reqValid_Req[j] && (cand_dist < pick_dist)) begin
        pick_dist = cand_dist;
        pick_idx  = idx_t'(j);
        pick_addr = reqAddress_Req[j*ADDR_W +: ADDR_W];
        pick_data = reqDataIn_Req[j*DATA_W +: DATA_W];
        pick_wen  = reqWen_Req[j];
      end
    end
  end

  assign pick_any = |reqValid_Req;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    rdata_d = rdata_q;
    hit_d   = '0;
`ifdef ARB_TIMEOUT_EN
    timer_d = timer_q;
    err_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          grant_d = pick_idx;
          last_d  = pick_idx;
          valid_d = 1'b1;
          addr_d  = pick_addr;
          wdata_d = pick_data;
          wen_d   = pick_wen;
`ifdef ARB_TIMEOUT_EN
          timer_d = '0;
`endif
        end
      end
      BUSY: begin
        // A hit in the limit cycle takes precedence over the watchdog.
        if (respHit_CPU) begin
          state_d = GAP;
          valid_d = 1'b0;
          rdata_d = respDataOut_CPU;
          hit_d   = NUM_REQ'(1) << grant_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (timer_q == TIMER_LAST) begin
          state_d = GAP;
          valid_d = 1'b0;
          err_d   = NUM_REQ'(1) << grant_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= idx_t'(NUM_REQ - 1);
      grant_q <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
      hit_q   <= '0;
`ifdef ARB_TIMEOUT_EN
      timer_q <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
`ifdef ARB_TIMEOUT_EN
      timer_q <= timer_d;
      err_q   <= err_d;
`endif
    end
  end

  assign reqValid_CPU    = valid_q;
  assign reqAddress_CPU  = addr_q;
  assign reqDataIn_CPU   = wdata_q;
  assign reqWen_CPU      = wen_q;
  assign respDataOut_Req = rdata_q;
  assign respHit_Req     = hit_q;
  assign grant_id        = grant_q;
`ifdef ARB_TIMEOUT_EN
  assign respErr_Req     = err_q;
`else
  assign respErr_Req     = '0;
`endif

endmodule
